round_ctrl_16_12: RTL and testbench
===================================

# round_ctrl_16_12

Streaming rounding controller that sequences a 16-bit to 12-bit signed rounding datapath. Sits between a 16-bit sample producer and a 12-bit consumer, with valid/ready handshakes on both sides. Holds a host-programmable rounding mode and applies mode changes only on a frame boundary, after draining the pipeline. Counts overflow events and optionally saturates them.

## Interface
- `OVF_CNT_W`, default 16, width of the overflow event counter.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_mode_i`  in  2  requested mode: 0 floor (truncate), 1 round-half-up, 2 toward-zero, 3 round-half-even.
- `cfg_we_i`  in  1  one-cycle strobe that writes `cfg_mode_i` into the pending-mode register.
- `cfg_mode_o`  out  2  mode currently in effect.
- `cfg_busy_o`  out  1  high while a pending mode has not yet been applied.
- `in_data_i`  in  16  signed Q11.4 sample.
- `in_last_i`  in  1  marks the last sample of a frame.
- `in_valid_i` / `in_ready_o`  in/out  1  input handshake.
- `out_data_o`  out  12  signed rounded result.
- `out_last_o`  out  1  `in_last_i` carried through the pipeline with its sample.
- `out_ovf_o`  out  1  the result overflowed the 12-bit range.
- `out_valid_o` / `out_ready_i`  out/in  1  output handshake.
- `ovf_cnt_o`  out  `OVF_CNT_W`  count of overflow events, saturating.
- `ovf_clr_i`  in  1  synchronous clear of `ovf_cnt_o`.

## Operation
- Arithmetic, with t = in[15:4] (signed), g = in[3], s = |in[2:0].
  - Mode 0 (floor): increment 0.
  - Mode 1 (round-half-up): increment g.
  - Mode 2 (toward-zero): increment in[15] & (g|s).
  - Mode 3 (round-half-even): increment g & (in[4]|s).
- Sum computed 13 bits wide. Overflow when t = 0x7FF and increment = 1. Negative overflow cannot occur.
- Pipeline has two stages:
  - S1 registers the sample, last flag and mode.
  - S2 registers the rounded result, overflow flag and last flag.
- Each sample uses the mode latched with it in S1.
- Backpressure: a stage advances when the stage after it is empty or advancing. `in_ready_o` = FSM permits input & S1 can advance. Full throughput when `out_ready_i` is held high.
- FSM states:
  - RUN: accept input. On a transfer with `in_last_i`=1 and a pending mode, go to DRAIN. On `cfg_we_i` while S1 and S2 are both empty and no input transfer occurs that cycle, go to APPLY.
  - DRAIN: `in_ready_o`=0. Go to APPLY when S1 and S2 are both empty.
  - APPLY: one cycle. Active mode takes the pending value, `cfg_busy_o` clears, return to RUN. `in_ready_o`=0 during APPLY.
- Pending mode:
  - `cfg_we_i` always overwrites the pending value and sets busy; the last write wins.
  - A `cfg_we_i` in the APPLY cycle is held pending, and busy stays set.
- Overflow counter:
  - Increments by 1 on every output transfer with `out_ovf_o`=1, and holds at all-ones.
  - `ovf_clr_i` takes priority over a simultaneous increment; the counter becomes 0.
- Reset values:
  - FSM = RUN, active mode = 0, pending flag clear, S1/S2 empty.
  - All outputs are 0, except `in_ready_o`, which is 1 from the first cycle after reset deassertion.
- Reset mid-operation discards in-flight samples and any pending mode.

## Timing
- Latency: a sample accepted in cycle N is presented on `out_*` in cycle N+2 when no stall occurs.
- `out_valid_o` and `out_data_o` stay stable while `out_valid_o`=1 and `out_ready_i`=0.
- Mode change on an idle pipeline: `cfg_we_i` in cycle N, APPLY in cycle N+1, new mode visible on `cfg_mode_o` and input accepted in cycle N+2.
- Mode change mid-stream: the first sample after the last-flagged sample is accepted no earlier than 4 cycles after the last-flagged transfer.
- All outputs are registered.

## Configuration
- `ROUND_SAT_EN` defined: an overflowing result is clamped to 0x7FF.
- `ROUND_SAT_EN` undefined: an overflowing result wraps to 0x800.
- `out_ovf_o` and `ovf_cnt_o` behave identically in both builds.

## Test plan
- Mode 1, inputs 0x0018, 0x0028, 0xFFE8 -> outputs 0x002, 0x003, 0xFFF, each 2 cycles after acceptance.
- Mode 3, the same inputs -> 0x002, 0x002, 0xFFE. Mode 2, input 0xFFE8 -> 0xFFF. Mode 0, input 0xFFE8 -> 0xFFE.
- Mode 1, input 0x7FF8 -> `out_ovf_o`=1 and `ovf_cnt_o` increments to 1. Output is 0x7FF with `ROUND_SAT_EN`, 0x800 without. `ovf_clr_i` asserted together with a second overflow transfer -> counter reads 0.
- Stream of 8 samples, `out_ready_i` toggled pseudo-randomly -> no loss, no duplication, order preserved, data held stable during stalls.
- `cfg_we_i` (mode 3) mid-frame -> current frame finishes in the old mode. `in_ready_o` is low from the last-flagged transfer until APPLY. First sample of the next frame rounds with mode 3. `cfg_busy_o` goes high to low.
- Assert `rst_n` low with 2 samples in flight and a mode pending -> `out_valid_o`=0, `cfg_mode_o`=0, `cfg_busy_o`=0 immediately. `in_ready_o`=1 in the first cycle after release.

Source files
------------

// File: rtl/round_ctrl_16_12.sv
// rtl/round_ctrl_16_12.sv - two-stage 16-to-12-bit signed rounding pipeline with frame-aligned mode changes
// Optional: ROUND_SAT_EN clamps overflowing results to 0x7FF instead of wrapping to 0x800.
module round_ctrl_16_12 #(
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           cfg_mode_i,
    input  logic                 cfg_we_i,
    output logic [1:0]           cfg_mode_o,
    output logic                 cfg_busy_o,
    input  logic [15:0]          in_data_i,
    input  logic                 in_last_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [11:0]          out_data_o,
    output logic                 out_last_o,
    output logic                 out_ovf_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OVF_CNT_W-1:0] ovf_cnt_o,
    input  logic                 ovf_clr_i
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 rdy_q;
    logic [1:0]           act_mode_q, act_mode_d;
    logic [1:0]           pend_mode_q, pend_mode_d;
    logic                 pend_q, pend_d;

    logic                 s1_valid_q, s1_valid_d;
    logic [15:0]          s1_data_q, s1_data_d;
    logic                 s1_last_q, s1_last_d;
    logic [1:0]           s1_mode_q, s1_mode_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [11:0]          s2_data_q, s2_data_d;
    logic                 s2_last_q, s2_last_d;
    logic                 s2_ovf_q, s2_ovf_d;

    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic                 s2_adv, s1_adv, in_fire, out_fire, pipe_empty;
    logic [11:0]          trunc;
    logic                 guard, sticky, inc, ovf;
    logic [12:0]          sum13;
    logic [11:0]          res;

    assign s2_adv     = !s2_valid_q || out_ready_i;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_ready_o = rdy_q && (state_q == ST_RUN) && s1_adv;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = s2_valid_q && out_ready_i;
    assign pipe_empty = !s1_valid_q && !s2_valid_q;

    // Rounding operates on the S1 sample with the mode captured alongside it.
    always_comb begin
        trunc  = s1_data_q[15:4];
        guard  = s1_data_q[3];
        sticky = |s1_data_q[2:0];
        case (s1_mode_q)
            2'd0:    inc = 1'b0;
            2'd1:    inc = guard;
            2'd2:    inc = s1_data_q[15] && (guard || sticky);
            default: inc = guard && (s1_data_q[4] || sticky);
        endcase
        sum13 = {trunc[11], trunc} + {12'd0, inc};
        ovf   = sum13[12] ^ sum13[11];
`ifdef ROUND_SAT_EN
        res   = ovf ? 12'h7FF : sum13[11:0];
`else
        res   = sum13[11:0];
`endif
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        s1_mode_d  = s1_mode_q;
        if (s1_adv) begin
            s1_valid_d = in_fire;
            if (in_fire) begin
                s1_data_d = in_data_i;
                s1_last_d = in_last_i;
                s1_mode_d = act_mode_q;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_last_d  = s2_last_q;
        s2_ovf_d   = s2_ovf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = res;
                s2_last_d = s1_last_q;
                s2_ovf_d  = ovf;
            end
        end

        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr_i) begin
            ovf_cnt_d = '0;
        end else if (out_fire && s2_ovf_q && !(&ovf_cnt_q)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    // A write during APPLY lands after the active mode is taken, so it stays pending.
    always_comb begin
        state_d     = state_q;
        act_mode_d  = act_mode_q;
        pend_mode_d = pend_mode_q;
        pend_d      = pend_q;
        case (state_q)
            ST_RUN: begin
                if (in_fire && in_last_i && (pend_q || cfg_we_i)) begin
                    state_d = ST_DRAIN;
                end else if (cfg_we_i && pipe_empty && !in_fire) begin
                    state_d = ST_APPLY;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_APPLY;
                end
            end
            default: begin
                act_mode_d = pend_mode_q;
                pend_d     = 1'b0;
                state_d    = ST_RUN;
            end
        endcase
        if (cfg_we_i) begin
            pend_mode_d = cfg_mode_i;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            rdy_q       <= 1'b0;
            act_mode_q  <= 2'd0;
            pend_mode_q <= 2'd0;
            pend_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_last_q   <= 1'b0;
            s1_mode_q   <= 2'd0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_last_q   <= 1'b0;
            s2_ovf_q    <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            act_mode_q  <= act_mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_last_q   <= s1_last_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_last_q   <= s2_last_d;
            s2_ovf_q    <= s2_ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign cfg_mode_o  = act_mode_q;
    assign cfg_busy_o  = pend_q;
    assign out_data_o  = s2_data_q;
    assign out_last_o  = s2_last_q;
    assign out_ovf_o   = s2_ovf_q;
    assign out_valid_o = s2_valid_q;
    assign ovf_cnt_o   = ovf_cnt_q;

endmodule

// File: tb/tb_round_ctrl_16_12.sv
// tb/tb_round_ctrl_16_12.sv - directed self-checking bench for round_ctrl_16_12
module tb_round_ctrl_16_12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_mode_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_mode_o;
    logic        cfg_busy_o;
    logic [15:0] in_data_i;
    logic        in_last_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [11:0] out_data_o;
    logic        out_last_o;
    logic        out_ovf_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] ovf_cnt_o;
    logic        ovf_clr_i;

    int n_chk  = 0;
    int n_fail = 0;

    round_ctrl_16_12 #(.OVF_CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_mode_i  (cfg_mode_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_mode_o  (cfg_mode_o),
        .cfg_busy_o  (cfg_busy_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_ovf_o   (out_ovf_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .ovf_cnt_o   (ovf_cnt_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rounding written with integer arithmetic rather than bit fields.
    function automatic logic [11:0] model(input logic [15:0] x, input logic [1:0] m);
        int v;
        int q;
        int r;
        v = int'($signed(x));
        r = v & 15;
        case (m)
            2'd0: q = v >>> 4;
            2'd1: q = (v + 8) >>> 4;
            2'd2: q = (v < 0) ? -((-v) >>> 4) : (v >>> 4);
            default: begin
                q = v >>> 4;
                if (r > 8) q = q + 1;
                else if (r == 8) q = q + (q & 1);
            end
        endcase
`ifdef ROUND_SAT_EN
        if (q > 2047) q = 2047;
`endif
        return q[11:0];
    endfunction

    task automatic set_mode(input logic [1:0] m);
        cfg_mode_i = m;
        cfg_we_i   = 1'b1;
        tick();
        cfg_we_i   = 1'b0;
        chk("busy_set", cfg_busy_o, 1);
        tick();
        chk("mode_applied", cfg_mode_o, m);
        chk("busy_clr", cfg_busy_o, 0);
        chk("ready_after_apply", in_ready_o, 1);
    endtask

    task automatic round_one(input logic [15:0] d, input logic [11:0] exp, input logic exp_ovf);
        in_valid_i = 1'b1;
        in_data_i  = d;
        chk("accept_ready", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
        chk("lat_not_early", out_valid_o, 0);
        tick();
        chk("lat_valid", out_valid_o, 1);
        chk("out_data", out_data_o, exp);
        chk("out_ovf", out_ovf_o, exp_ovf);
        tick();
    endtask

    logic [15:0] vec [8] = '{16'h0018, 16'h0028, 16'hFFE8, 16'h7FF8,
                             16'h1234, 16'h8000, 16'hFFF7, 16'h0A5C};
    logic [11:0] exp_q [$];
    int          sent;
    int          rcvd;
    logic        stall_prev;
    logic [11:0] held;
    logic [11:0] sat_val;

    initial begin
`ifdef ROUND_SAT_EN
        sat_val = 12'h7FF;
`else
        sat_val = 12'h800;
`endif
        rst_n = 1'b0; cfg_mode_i = 2'd0; cfg_we_i = 1'b0; in_data_i = '0;
        in_last_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; ovf_clr_i = 1'b0;
        #12;
        chk("rst_ready", in_ready_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_mode", cfg_mode_o, 0);
        chk("rst_busy", cfg_busy_o, 0);
        chk("rst_cnt", ovf_cnt_o, 0);
        #8 rst_n = 1'b1;
        tick();
        chk("ready_after_rst", in_ready_o, 1);

        set_mode(2'd1);
        round_one(16'h0018, 12'h002, 1'b0);
        round_one(16'h0028, 12'h003, 1'b0);
        round_one(16'hFFE8, 12'hFFF, 1'b0);
        set_mode(2'd3);
        round_one(16'h0018, 12'h002, 1'b0);
        round_one(16'h0028, 12'h002, 1'b0);
        round_one(16'hFFE8, 12'hFFE, 1'b0);
        set_mode(2'd2);
        round_one(16'hFFE8, 12'hFFF, 1'b0);
        set_mode(2'd0);
        round_one(16'hFFE8, 12'hFFE, 1'b0);

        set_mode(2'd1);
        round_one(16'h7FF8, sat_val, 1'b1);
        chk("ovf_cnt_one", ovf_cnt_o, 1);
        in_valid_i = 1'b1;
        in_data_i  = 16'h7FF8;
        tick();
        in_valid_i = 1'b0;
        tick();
        chk("ovf_second", out_ovf_o, 1);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("ovf_clr_prio", ovf_cnt_o, 0);

        sent = 0; rcvd = 0; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 300 && rcvd < 8; cyc++) begin
            out_ready_i = 1'($urandom_range(0, 1));
            in_valid_i  = (sent < 8);
            in_data_i   = vec[(sent < 8) ? sent : 7];
            in_last_i   = (sent == 7);
            #1;
            if (stall_prev) begin
                chk("stall_valid", out_valid_o, 1);
                chk("stall_data", out_data_o, held);
            end
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back(model(in_data_i, 2'd1));
                sent++;
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra", exp_q.size(), 1);
                end else begin
                    chk("stream_data", out_data_o, exp_q.pop_front());
                end
                chk("stream_last", out_last_o, (rcvd == 7));
                rcvd++;
            end
            stall_prev = out_valid_o && !out_ready_i;
            held       = out_data_o;
            @(posedge clk);
            #1;
        end
        chk("stream_count", rcvd, 8);
        in_valid_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b1;
        tick();
        tick();

        in_valid_i = 1'b1; in_data_i = 16'h0028; in_last_i = 1'b0;
        tick();
        cfg_we_i = 1'b1; cfg_mode_i = 2'd3;
        tick();
        cfg_we_i = 1'b0;
        chk("mf_out0", out_data_o, 12'h003);
        chk("mf_busy", cfg_busy_o, 1);
        in_last_i = 1'b1;
        chk("mf_ready_last", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0; in_last_i = 1'b0;
        chk("drain_ready0", in_ready_o, 0);
        chk("mf_out1", out_data_o, 12'h003);
        tick();
        chk("drain_ready1", in_ready_o, 0);
        chk("mf_out2", out_data_o, 12'h003);
        chk("mf_out2_last", out_last_o, 1);
        tick();
        chk("drain_ready2", in_ready_o, 0);
        chk("drain_empty", out_valid_o, 0);
        tick();
        chk("apply_ready", in_ready_o, 0);
        chk("apply_old_mode", cfg_mode_o, 1);
        chk("apply_busy", cfg_busy_o, 1);
        tick();
        chk("new_frame_ready", in_ready_o, 1);
        chk("new_mode", cfg_mode_o, 3);
        chk("new_busy", cfg_busy_o, 0);
        round_one(16'h0028, 12'h002, 1'b0);

        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 16'h0018; cfg_we_i = 1'b1; cfg_mode_i = 2'd2;
        tick();
        cfg_we_i = 1'b0;
        tick();
        in_valid_i = 1'b0;
        chk("inflight_valid", out_valid_o, 1);
        chk("inflight_busy", cfg_busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid_o, 0);
        chk("midrst_mode", cfg_mode_o, 0);
        chk("midrst_busy", cfg_busy_o, 0);
        chk("midrst_ready", in_ready_o, 0);
        #2 rst_n = 1'b1;
        out_ready_i = 1'b1;
        tick();
        chk("midrst_ready_after", in_ready_o, 1);
        chk("midrst_valid_after", out_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
